// File: rtl/hoene_protocol_pkg.sv
// Shared definitions for the hoene serial link, used by both transmitter and receiver.
package hoene_protocol_pkg;

  // IDLE: wait for a byte | PREAMBLE: send sync pattern | DATA: payload bytes | GAP: quiet line
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } hoene_state_e;

  localparam logic [7:0] HOENE_PREAMBLE = 8'hAB;
  localparam int         BIT_CNT_W      = 3;
  localparam int         GAP_CNT_W      = 12;

  function automatic logic in_frame(input hoene_state_e s);
    return (s == PREAMBLE) || (s == DATA);
  endfunction

endpackage

// File: rtl/hoene_bit_timer.sv
// Bit-period divider: while enabled, strobes once every BIT_DIV cycles, first strobe BIT_DIV-1 cycles after enable.
module hoene_bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  output logic o_strobe
);

  localparam logic [7:0] LAST = 8'(BIT_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !i_enable) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_strobe = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/hoene_protocol_tx.sv
// Hoene serial transmitter: sends 8'hAB preamble then back-to-back payload bytes MSB first,
// one bit per out_clk strobe, and closes each frame with an out_error resync pulse and a quiet gap.
module hoene_protocol_tx
  import hoene_protocol_pkg::*;
#(
  parameter int BIT_DIV  = 4,
  parameter int GAP_BITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_abort,
  output logic       out_data,
  output logic       out_clk,
  output logic       out_error,
  output logic       busy
);

  localparam int                   GAP_CYCLES = GAP_BITS * BIT_DIV;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST   = GAP_CNT_W'(GAP_CYCLES - 1);

  hoene_state_e         r_state, w_state;
  logic                 r_hold_full, w_hold_full;
  logic [7:0]           r_hold, w_hold;
  logic [6:0]           r_shift, w_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt, w_bit_cnt;
  logic [GAP_CNT_W-1:0] r_gap_cnt, w_gap_cnt;
  logic                 r_out_data, w_out_data;
  logic                 r_out_clk, w_out_clk;
  logic                 r_out_error, w_out_error;
  logic                 w_accept;
  logic                 w_tick;

  hoene_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (in_frame(r_state)),
    .o_strobe (w_tick)
  );

  assign tx_ready  = rst_n && !r_hold_full;
  assign w_accept  = tx_valid && tx_ready;
  assign out_data  = r_out_data;
  assign out_clk   = r_out_clk;
  assign out_error = r_out_error;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_out_data  <= 1'b0;
      r_out_clk   <= 1'b0;
      r_out_error <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_hold_full <= w_hold_full;
      r_hold      <= w_hold;
      r_shift     <= w_shift;
      r_bit_cnt   <= w_bit_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_out_data  <= w_out_data;
      r_out_clk   <= w_out_clk;
      r_out_error <= w_out_error;
    end
  end

  // Line outputs are registered, so every decision below appears on the pins one cycle later.
  always_comb begin
    w_state     = r_state;
    w_hold_full = r_hold_full;
    w_hold      = r_hold;
    w_shift     = r_shift;
    w_bit_cnt   = r_bit_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_out_data  = r_out_data;
    w_out_clk   = 1'b0;
    w_out_error = 1'b0;

    if (w_accept) begin
      w_hold_full = 1'b1;
      w_hold      = tx_data;
    end

    case (r_state)
      IDLE: begin
        w_out_data = 1'b0;
        if (r_hold_full) begin
          w_state    = PREAMBLE;
          w_shift    = HOENE_PREAMBLE[6:0];
          w_out_data = HOENE_PREAMBLE[7];
          w_out_clk  = 1'b1;
          w_bit_cnt  = '0;
        end
      end

      PREAMBLE, DATA: begin
        if (tx_abort) begin
          w_hold_full = 1'b0;
          w_out_error = 1'b1;
          w_out_data  = 1'b0;
          w_state     = GAP;
          w_gap_cnt   = GAP_LAST;
        end else if (w_tick) begin
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_hold_full) begin
              w_hold_full = 1'b0;
              w_shift     = r_hold[6:0];
              w_out_data  = r_hold[7];
              w_out_clk   = 1'b1;
              w_state     = DATA;
            end else begin
              w_out_data  = 1'b0;
              w_out_error = 1'b1;
              w_state     = GAP;
              w_gap_cnt   = GAP_LAST;
            end
          end else begin
            w_out_data = r_shift[6];
            w_shift    = {r_shift[5:0], 1'b0};
            w_out_clk  = 1'b1;
          end
        end
      end

      GAP: begin
        w_out_data = 1'b0;
        if (r_gap_cnt == '0) begin
          w_state = IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt - 12'd1;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hoene_protocol_tx.sv
// Self-checking bench for hoene_protocol_tx: frame vectors, abort/reset sequences, random frames, BIT_DIV=2 instance.
module tb_hoene_protocol_tx;

  localparam int BD  = 4;
  localparam int GB  = 4;
  localparam int BD2 = 2;

  logic clk;
  logic rst_n;
  logic [7:0] tx_data, tx_data2;
  logic tx_valid, tx_abort, tx_valid2, tx_abort2;
  logic tx_ready, out_data, out_clk, out_error, busy;
  logic tx_ready2, out_data2, out_clk2, out_error2, busy2;

  int checks = 0;
  int failures = 0;
  int cyc;

  hoene_protocol_tx #(.BIT_DIV(BD), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_abort(tx_abort), .out_data(out_data), .out_clk(out_clk), .out_error(out_error), .busy(busy)
  );

  hoene_protocol_tx #(.BIT_DIV(BD2), .GAP_BITS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .tx_abort(tx_abort2), .out_data(out_data2), .out_clk(out_clk2), .out_error(out_error2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Line monitor plus a behavioural receiver: sync on the last 8 bits equal to 8'hAB, then bytes of 8 bits.
  int st_cyc[$], err_cyc[$], sync_q[$];
  logic st_bit[$];
  logic [7:0] rx_bytes[$];
  int viol = 0, idle_viol = 0;
  logic prev_d = 1'b0;
  logic rx_insync = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  int fstrobes = 0, rcnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (out_clk) begin
        st_cyc.push_back(cyc);
        st_bit.push_back(out_data);
      end
      if (out_error) err_cyc.push_back(cyc);
      if (rst_n && !out_clk && !out_error && (out_data !== prev_d)) viol++;
      if (!busy && out_data) idle_viol++;
      prev_d = out_data;
      if (!rst_n || out_error) begin
        rx_insync = 1'b0; rx_sh = 8'h00; fstrobes = 0; rcnt = 0;
      end else if (out_clk) begin
        fstrobes++;
        rx_sh = {rx_sh[6:0], out_data};
        if (!rx_insync) begin
          if (rx_sh == 8'hAB) begin
            rx_insync = 1'b1;
            sync_q.push_back(fstrobes);
            rcnt = 0;
          end
        end else begin
          rcnt++;
          if (rcnt == 8) begin
            rx_bytes.push_back(rx_sh);
            rcnt = 0;
          end
        end
      end
    end
  end

  int st2[$];
  logic st2b[$];
  int viol2 = 0;
  logic prev2 = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (out_clk2) begin
        st2.push_back(cyc);
        st2b.push_back(out_data2);
      end
      if (rst_n && !out_clk2 && !out_error2 && (out_data2 !== prev2)) viol2++;
      prev2 = out_data2;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output int acc);
    tx_data = b;
    tx_valid = 1'b1;
    for (int t = 0; t < 3000 && !tx_ready; t++) @(negedge clk);
    chk("accept", tx_ready, 1);
    acc = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic push2(input logic [7:0] b, output int acc);
    tx_data2 = b;
    tx_valid2 = 1'b1;
    for (int t = 0; t < 3000 && !tx_ready2; t++) @(negedge clk);
    chk("accept2", tx_ready2, 1);
    acc = cyc;
    @(negedge clk);
    tx_valid2 = 1'b0;
  endtask

  task automatic run_frame(input string nm, input int n, input logic [31:0] pk,
                           input int exp_strobes, input int exp_err_off);
    int sb, eb, rb, qb, acc, acc0, fall_c, ns, mism_t, mism_b, mism_r, e;
    logic [39:0] s;
    s = {8'hAB, pk};
    sb = st_cyc.size(); eb = err_cyc.size(); rb = rx_bytes.size(); qb = sync_q.size();
    acc0 = 0;
    for (int i = 0; i < n; i++) begin
      push_byte(pk[31-8*i -: 8], acc);
      if (i == 0) acc0 = acc;
    end
    for (int t = 0; t < 50 && !busy; t++) @(negedge clk);
    for (int t = 0; t < 5000 && busy; t++) @(negedge clk);
    fall_c = cyc;
    @(negedge clk);
    chk({nm, "_idle"}, busy, 0);
    ns = st_cyc.size() - sb;
    chk({nm, "_strobes"}, ns, exp_strobes);
    chk({nm, "_first_strobe"}, (ns > 0) ? st_cyc[sb] - acc0 : -1, 2);
    mism_t = 0; mism_b = 0;
    for (int k = 0; k < ns && k < 40; k++) begin
      if (st_cyc[sb+k] != acc0 + 2 + k*BD) mism_t++;
      if (st_bit[sb+k] != s[39-k]) mism_b++;
    end
    chk({nm, "_strobe_timing_errs"}, mism_t, 0);
    chk({nm, "_bit_errs"}, mism_b, 0);
    chk({nm, "_err_pulses"}, err_cyc.size() - eb, 1);
    e = (err_cyc.size() > eb) ? err_cyc[eb] : -100000;
    chk({nm, "_err_time"}, e - acc0, exp_err_off);
    chk({nm, "_gap_cycles"}, fall_c - e, GB*BD);
    chk({nm, "_sync_strobe"}, (sync_q.size() > qb) ? sync_q[qb] : -1, 8);
    chk({nm, "_rx_count"}, rx_bytes.size() - rb, n);
    mism_r = 0;
    for (int i = 0; i < n && rb + i < rx_bytes.size(); i++)
      if (rx_bytes[rb+i] != pk[31-8*i -: 8]) mism_r++;
    chk({nm, "_rx_byte_errs"}, mism_r, 0);
    chk({nm, "_insync_cleared"}, rx_insync, 0);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] pk;
    int          exp_strobes;
    int          exp_err_off;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int sb, eb, acc, x, k, fall_c, n;
    logic drop;
    logic [31:0] pk;

    vecs[0] = '{"b5a",   1, 32'h5A000000, 16, 66};
    vecs[1] = '{"bc3",   1, 32'hC3000000, 16, 66};
    vecs[2] = '{"ff_00", 2, 32'hFF000000, 24, 98};
    vecs[3] = '{"00_ff", 2, 32'h00FF0000, 24, 98};
    vecs[4] = '{"b80",   1, 32'h80000000, 16, 66};

    rst_n = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; tx_abort = 1'b0;
    tx_data2 = 8'h00; tx_valid2 = 1'b0; tx_abort2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {out_data, out_clk, out_error, busy}, 0);
    chk("rst_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_tx_ready", tx_ready, 1);
    chk("release_busy", busy, 0);

    foreach (vecs[i]) begin
      repeat (2) @(negedge clk);
      run_frame(vecs[i].name, vecs[i].n, vecs[i].pk, vecs[i].exp_strobes, vecs[i].exp_err_off);
    end

    // Abort on the 3rd data strobe while a second byte waits in hold.
    @(negedge clk);
    sb = st_cyc.size(); eb = err_cyc.size();
    push_byte(8'h5A, acc);
    tx_data = 8'h3C; tx_valid = 1'b1;
    drop = 1'b0; k = 0;
    for (int t = 0; t < 3000 && k < 11; t++) begin
      @(negedge clk);
      if (drop) begin tx_valid = 1'b0; drop = 1'b0; end
      if (tx_valid && tx_ready) drop = 1'b1;
      if (out_clk) k++;
    end
    chk("abort_reached_strobe", k, 11);
    chk("abort_hold_full", tx_ready, 0);
    tx_valid = 1'b0;
    tx_abort = 1'b1;
    x = cyc;
    @(negedge clk);
    tx_abort = 1'b0;
    chk("abort_err_next", out_error, 1);
    chk("abort_hold_cleared", tx_ready, 1);
    chk("abort_busy_gap", busy, 1);
    for (int t = 0; t < 500 && busy; t++) @(negedge clk);
    fall_c = cyc;
    chk("abort_gap_cycles", fall_c - (x + 1), GB*BD);
    repeat (10) @(negedge clk);
    chk("abort_stays_idle", busy, 0);
    chk("abort_strobes", st_cyc.size() - sb, 11);
    chk("abort_err_pulses", err_cyc.size() - eb, 1);

    // Synchronous reset in the middle of the payload.
    push_byte(8'h96, acc);
    k = 0;
    for (int t = 0; t < 3000 && k < 12; t++) begin
      @(negedge clk);
      if (out_clk) k++;
    end
    chk("rst_mid_reached", k, 12);
    eb = err_cyc.size();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {out_data, out_clk, out_error, busy, tx_ready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", tx_ready, 1);
    chk("rst_mid_no_err", err_cyc.size() - eb, 0);
    run_frame("after_rst", 1, 32'hA5000000, 16, 66);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      pk = $urandom;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      run_frame($sformatf("rand%0d", r), n, pk, 8*(n+1), 2 + 8*(n+1)*BD);
    end

    chk("data_stable_viol", viol, 0);
    chk("idle_line_viol", idle_viol, 0);

    // BIT_DIV=2 instance with three back-to-back bytes.
    begin
      int acc0, mism_i, mism_b, ns;
      logic [31:0] s2;
      s2 = {8'hAB, 24'($urandom)};
      sb = st2.size();
      acc0 = 0;
      for (int i = 0; i < 3; i++) begin
        push2(s2[23-8*i -: 8], acc);
        if (i == 0) acc0 = acc;
      end
      for (int t = 0; t < 50 && !busy2; t++) @(negedge clk);
      for (int t = 0; t < 2000 && busy2; t++) @(negedge clk);
      @(negedge clk);
      ns = st2.size() - sb;
      chk("bd2_strobes", ns, 32);
      chk("bd2_first_strobe", (ns > 0) ? st2[sb] - acc0 : -1, 2);
      mism_i = 0; mism_b = 0;
      for (int j = 0; j < ns && j < 32; j++) begin
        if (j > 0 && st2[sb+j] - st2[sb+j-1] != 2) mism_i++;
        if (st2b[sb+j] != s2[31-j]) mism_b++;
      end
      chk("bd2_interval_errs", mism_i, 0);
      chk("bd2_bit_errs", mism_b, 0);
      chk("bd2_stable_viol", viol2, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hoene_protocol_tx.md
HOENE_PROTOCOL_TX -- requirements
Module: hoene_protocol_tx

Interface
REQ-001 SHALL have parameter BIT_DIV, default 4: clk cycles per bit period; legal range 2..255.
REQ-002 SHALL have parameter GAP_BITS, default 4: idle bit periods inserted after every frame end; legal range 1..15.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  payload byte, sent MSB first.
REQ-006 SHALL have port tx_valid  input  1  tx_data is valid.
REQ-007 SHALL have port tx_ready  output  1  holding register can accept a byte.
REQ-008 SHALL have port tx_abort  input  1  terminates the current frame immediately.
REQ-009 SHALL have port out_data  output  1  serial bit, feeds receiver in_data.
REQ-010 SHALL have port out_clk  output  1  one-cycle bit strobe, feeds receiver in_clk.
REQ-011 SHALL have port out_error  output  1  one-cycle resync pulse, feeds receiver in_error.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA and GAP.
REQ-014 SHALL hold one byte in a holding register; a transfer occurs when tx_valid && tx_ready; tx_ready = rst_n && !hold_full.
REQ-015 SHALL leave IDLE for PREAMBLE on the cycle after hold_full is set; the first out_clk pulse occurs 2 cycles after the accepting cycle.
REQ-016 SHALL transmit preamble 8'hAB MSB first (1,0,1,0,1,0,1,1) in PREAMBLE; the holding register is not consumed.
REQ-017 SHALL produce exactly one out_clk pulse every BIT_DIV cycles in PREAMBLE and DATA; out_data changes only in a strobe cycle and holds until the next strobe.
REQ-018 SHALL decide at each byte boundary (the strobe slot after bit 7): if hold_full, load the shift register, clear hold_full, strobe the MSB, and enter or stay in DATA.
REQ-019 SHALL end the frame at a byte boundary with hold empty: no strobe, out_data<=0, out_error=1 for one cycle, enter GAP.
REQ-020 SHALL on tx_abort in PREAMBLE or DATA: discard the partial byte, clear hold_full, pulse out_error for one cycle on the next cycle, drive out_data<=0 and enter GAP; tx_abort is ignored in IDLE and GAP.
REQ-021 SHALL stay in GAP for GAP_BITS*BIT_DIV cycles with no strobes and out_data=0, then enter IDLE; bytes may be accepted into hold during GAP.
REQ-022 SHALL never emit two consecutive 1 bits outside the last two preamble bits and payload bits, so the receiver cannot falsely sync.
REQ-023 SHALL, when tx_valid and a byte-boundary load coincide, apply the load first; the new byte is accepted on the next cycle via tx_ready.
REQ-024 SHALL count bits 0..7 with a 3-bit counter that wraps from 7 to 0 at the boundary; the divider counter wraps at BIT_DIV-1.

Reset
REQ-025 SHALL on rst_n low set state IDLE, clear hold_full, shift register, bit and divider counters, and drive out_data=0, out_clk=0, out_error=0, busy=0, tx_ready=0.
REQ-026 SHALL abort any frame in progress on reset without an out_error pulse; tx_ready=1 in the first cycle after release.

Structure
REQ-027 SHALL take the preamble constant 8'hAB and the state encoding from shared package hoene_protocol_pkg, which the receiver also uses.
REQ-028 SHALL put the bit-period divider in sub-module hoene_bit_timer (enable in, strobe out, parameter BIT_DIV).

Verification
REQ-029 SHALL check: single byte 8'h5A, BIT_DIV=4 -> 16 strobes, bits 10101011 01011010, then a one-cycle out_error, GAP of 16 cycles, then IDLE.
REQ-030 SHALL check: bytes 8'hFF, 8'h00 with tx_valid held -> 24 strobes with no gap between bytes, tx_ready rising once per byte.
REQ-031 SHALL check: tx_abort at the 3rd data strobe -> no further strobes, out_error pulse on the next cycle, hold cleared, busy low after the GAP.
REQ-032 SHALL check: rst_n low mid-DATA -> all outputs 0 on the next edge, no out_error pulse, and a fresh frame restarts with the preamble.
REQ-033 SHALL check: loopback into the receiver with 8'hC3 -> insync rises at the 8th strobe and the received bytes match; receiver insync clears on out_error.
REQ-034 SHALL check: BIT_DIV=2 with back-to-back bytes -> strobes exactly 2 cycles apart and out_data stable between strobes.
